led_pattern_gen: RTL and testbench

//  Parametrised LED pattern engine; successor to the fixed 1 Hz LED binary counter.

---
 rtl/led_pattern_gen.sv | 110 +++++++++++
 tb/tb_led_pattern_gen.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - LED pattern engine: run-time rate prescaler, four step modes, pause and single-step
module led_pattern_gen #(
  parameter int LED_W   = 8,
  parameter int CLK_HZ  = 50_000_000,
  parameter int STEP_HZ = 1,
  parameter int RATE_W  = 2
) (
  input  logic              CLK50MHZ,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic [RATE_W-1:0] rate,
  input  logic              pause,
  input  logic              step,
  output logic [LED_W-1:0]  led,
  output logic              tick,
  output logic              dir
);

  localparam int DIV   = CLK_HZ / STEP_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_SCAN = 2'd2;

  generate
    if (((DIV >> (2**RATE_W - 1)) < 1) || (LED_W < 2)) begin : g_param_check
      $error("led_pattern_gen: DIV too small for fastest rate, or LED_W < 2");
    end
  endgenerate

  logic [1:0]       mode_q;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      term;
  logic             at_term;
  logic             adv;
  logic [LED_W-1:0] seed;
  logic [LED_W-1:0] led_step;
  logic             dir_step;

  // Compare with >= so a mid-count rate increase wraps on the next cycle instead of overrunning.
  assign term    = (32'(DIV) >> rate) - 32'd1;
  assign at_term = 32'(cnt) >= term;
  assign adv     = pause ? step : at_term;

  always_comb begin
    seed = LED_W'(1);
    case (mode)
      MODE_UP:   seed = '0;
      MODE_DOWN: seed = '1;
      default:   seed = LED_W'(1);
    endcase
  end

  always_comb begin
    led_step = led;
    dir_step = dir;
    case (mode_q)
      MODE_UP:   led_step = led + LED_W'(1);
      MODE_DOWN: led_step = led - LED_W'(1);
      MODE_SCAN: begin
        // Endpoints turn around immediately, so MSB and LSB are each shown for a single step.
        if (!dir) begin
          if (led[LED_W-1]) begin
            dir_step = 1'b1;
            led_step = led >> 1;
          end else begin
            led_step = led << 1;
          end
        end else begin
          if (led[0]) begin
            dir_step = 1'b0;
            led_step = led << 1;
          end else begin
            led_step = led >> 1;
          end
        end
      end
      default:   led_step = {led[LED_W-2:0], led[LED_W-1]};
    endcase
  end

  always_ff @(posedge CLK50MHZ) begin
    if (reset) begin
      led    <= '0;
      tick   <= 1'b0;
      dir    <= 1'b0;
      mode_q <= MODE_UP;
      cnt    <= '0;
    end else if (mode != mode_q) begin
      mode_q <= mode;
      cnt    <= '0;
      tick   <= 1'b0;
      led    <= seed;
      if (mode == MODE_SCAN) begin
        dir <= 1'b0;
      end
    end else begin
      if (!pause) begin
        cnt <= at_term ? '0 : cnt + CNT_W'(1);
      end
      tick <= adv;
      if (adv) begin
        led <= led_step;
        dir <= dir_step;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - scoreboard bench for led_pattern_gen with DIV=16
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [1:0] rate;
  logic       pause;
  logic       step;
  logic [7:0] led;
  logic       tick;
  logic       dir;

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] sb_q[$];

  led_pattern_gen #(.LED_W(8), .CLK_HZ(16), .STEP_HZ(1), .RATE_W(2)) dut (
    .CLK50MHZ(clk), .reset(reset), .mode(mode), .rate(rate),
    .pause(pause), .step(step), .led(led), .tick(tick), .dir(dir)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic d, input logic [7:0] v);
    sb_q.push_back({d, v});
  endtask

  task automatic wait_tick(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!tick && cycles < budget);
    if (!tick) check_val("tick_timeout", 32'(tick), 1);
  endtask

  // Waits for the next tick, then pops the scoreboard and checks interval, led and dir.
  task automatic expect_step(input string tag, input int period);
    int c;
    logic [8:0] e;
    wait_tick(64, c);
    e = sb_q.pop_front();
    check_val({tag, "_period"}, c, period);
    check_val({tag, "_led"}, 32'(led), 32'(e[7:0]));
    check_val({tag, "_dir"}, 32'(dir), 32'(e[8]));
  endtask

  initial begin
    int ticks;
    logic prev;
    logic [8:0] e;

    reset = 1'b1; mode = 2'd0; rate = 2'd0; pause = 1'b0; step = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_led", 32'(led), 0);
    check_val("rst_tick", 32'(tick), 0);
    check_val("rst_dir", 32'(dir), 0);
    reset = 1'b0;

    for (int i = 1; i <= 3; i++) push(1'b0, 8'(i));
    for (int i = 0; i < 3; i++) expect_step("up", 16);

    repeat (5) @(negedge clk);
    rate = 2'd3;
    push(1'b0, 8'd4);
    expect_step("rate_up", 1);
    for (int v = 5; v <= 257; v++) push(1'b0, 8'(v));
    for (int v = 5; v <= 257; v++) expect_step("up_wrap", 2);

    mode = 2'd2; rate = 2'd2;
    @(negedge clk);
    check_val("scan_seed_led", 32'(led), 1);
    check_val("scan_seed_dir", 32'(dir), 0);
    check_val("scan_seed_tick", 32'(tick), 0);
    for (int k = 1; k <= 7; k++) push(1'b0, 8'(1 << k));
    for (int k = 6; k >= 0; k--) push(1'b1, 8'(1 << k));
    push(1'b0, 8'd2);
    for (int k = 0; k < 15; k++) expect_step("scan", 4);

    repeat (2) @(negedge clk);
    pause = 1'b1; step = 1'b1;
    push(1'b0, 8'd4); push(1'b0, 8'd8); push(1'b0, 8'd16);
    ticks = 0;
    prev = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (tick) ticks++;
      check_val("pause_tick", 32'(tick), 32'(prev));
      if (prev) begin
        e = sb_q.pop_front();
        check_val("pause_led", 32'(led), 32'(e[7:0]));
      end
      prev = (i == 10 || i == 25);
      step = prev;
    end
    check_val("pause_ticks", ticks, 3);
    pause = 1'b0;
    push(1'b0, 8'd32);
    expect_step("unpause", 2);

    mode = 2'd0; rate = 2'd0;
    @(negedge clk);
    check_val("up_seed_led", 32'(led), 0);
    repeat (9) @(negedge clk);
    mode = 2'd3;
    @(negedge clk);
    check_val("rot_seed_led", 32'(led), 1);
    check_val("rot_seed_tick", 32'(tick), 0);
    push(1'b0, 8'd2); push(1'b0, 8'd4);
    expect_step("rot", 16);
    expect_step("rot", 16);
    rate = 2'd3;
    for (int k = 3; k <= 8; k++) push(1'b0, 8'(1 << (k % 8)));
    for (int k = 3; k <= 8; k++) expect_step("rot_fast", 2);

    mode = 2'd1;
    @(negedge clk);
    check_val("down_seed_led", 32'(led), 255);
    for (int v = 254; v >= -1; v--) push(1'b0, 8'(v));
    for (int v = 254; v >= -1; v--) expect_step("down", 2);

    mode = 2'd2; rate = 2'd2;
    @(negedge clk);
    check_val("scan2_seed_led", 32'(led), 1);
    for (int k = 1; k <= 7; k++) push(1'b0, 8'(1 << k));
    push(1'b1, 8'd64);
    for (int k = 0; k < 8; k++) expect_step("scan2", 4);
    pause = 1'b1; step = 1'b1; reset = 1'b1;
    @(negedge clk);
    check_val("midrst_led", 32'(led), 0);
    check_val("midrst_dir", 32'(dir), 0);
    check_val("midrst_tick", 32'(tick), 0);
    reset = 1'b0; pause = 1'b0; step = 1'b0;
    @(negedge clk);
    check_val("reseed_led", 32'(led), 1);
    check_val("reseed_dir", 32'(dir), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
